ps2_scan_rx: RTL and testbench
==============================

# ps2_scan_rx

Receives device-to-host PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` lines and produces one byte per valid frame on `code`, with a single-cycle `new_code` strobe and a `makeBreak` flag. It is the producer side of the `code`/`new_code`/`makeBreak` interface consumed by the seven-segment history display and the make/break LED shifter. It synchronises and filters the PS/2 lines, checks framing and parity, tracks `F0`/`E0` prefixes, and recovers from stalled frames with a watchdog.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a filtered falling edge before a frame in progress is abandoned (2 ms at 50 MHz).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `code`  out  8  last accepted byte; held until the next accepted byte.
- `new_code`  out  1  one-cycle strobe, high in the cycle `code` takes a new value.
- `makeBreak`  out  1  valid while `new_code` is high: 1 = make byte, 0 = `F0` prefix or the byte following `F0`.
- `extended`  out  1  valid while `new_code` is high: 1 when the byte is `E0` or follows `E0`.
- `frame_err`  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Both inputs pass through a 2-flop synchroniser. `ps2_clk` is then filtered: its level changes only after `FILTER_LEN` consecutive equal samples. The filtered level resets to 1.
- Falling edge (`fall`) is a 1→0 transition of the filtered clock. `ps2_data` is sampled only on `fall`, taking the synchronised value from the same cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM:
  - IDLE: on `fall`, if data=0 go to DATA with bit count 0. If data=1, stay in IDLE (glitch).
  - DATA: shift each sampled bit into the LSB-first shift register. After the 8th bit, go to PARITY.
  - PARITY: store the sampled bit, then go to STOP.
  - STOP: accept the frame if the stop bit is 1 and the XOR of the 8 data bits and parity bit is 1; otherwise raise `frame_err`. Return to IDLE in either case.
- Watchdog: the counter clears on every `fall` and in IDLE, and counts in all other states. Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err`, and discards partial data.
- Prefix tracking on each accepted byte:
  - `F0`: output with makeBreak=0. Sets `brk_pend`.
  - `E0`: output with extended=1 and makeBreak=1 (or 0 if `brk_pend` is already set). Sets `ext_pend`.
  - Any other byte: output with makeBreak=!brk_pend and extended=ext_pend. Then clear both pend flags.
- Every accepted byte, prefixes included, raises `new_code`, so the display shows the raw byte stream.
- Rejected frames do not change `code`, the pend flags, `makeBreak` or `extended`.

## Timing
- Reset values: `code`=0, `new_code`=0, `makeBreak`=0, `extended`=0, `frame_err`=0, FSM=IDLE, pend flags=0, filtered clock=1, watchdog=0.
- Reset is asynchronous mid-frame: the partial frame is dropped and no strobe is issued.
- Input latency is 2 synchroniser cycles plus `FILTER_LEN` cycles, from raw `ps2_clk` fall to the `fall` cycle.
- Output latency: if the stop-bit `fall` occurs in cycle N, then `code`, `makeBreak`, `extended` and `new_code` (or `frame_err`) are registered and visible in cycle N+1.
- `new_code` and `frame_err` are never high in the same cycle. Neither is ever high for two consecutive cycles.
- If a `fall` and the watchdog expiry land in the same cycle, the `fall` wins: the watchdog clears and the bit is sampled.
- A `fall` in IDLE with data=1 produces no output and no error.

## Test plan
- Make code: send frame 0x1C with parity 0 and stop 1 → one `new_code` pulse, `code`=0x1C, makeBreak=1, extended=0, no `frame_err`.
- Break sequence: send `F0` then `1C` → two strobes: (0xF0, makeBreak=0) then (0x1C, makeBreak=0). A following `1C` gives makeBreak=1.
- Extended break: send `E0 F0 75` → strobes give extended = 1,1,1 and makeBreak = 1,0,0. A following `75` gives extended=0, makeBreak=1.
- Parity error: send 0x1C with parity 1 → `frame_err` pulse, no `new_code`, `code` still holds its previous value. A following valid `1C` is accepted normally.
- Timeout: stop `ps2_clk` after 4 data bits, hold high for `TIMEOUT_CYCLES`+10 → one `frame_err` pulse, FSM back in IDLE. A next full frame 0x2A is received correctly.
- Glitch and reset: a 3-cycle low pulse on `ps2_clk` (< `FILTER_LEN`) → no bit sampled. Asserting `rst` after 5 bits → all outputs 0, and a subsequent frame 0x1C is accepted.

Source files
------------

// File: rtl/ps2_scan_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_scan_rx_if
// Scan-code bus between the PS/2 receiver (master, producer) and its
// consumers such as the seven-segment history display and the make/break
// LED shifter (slave).
//   code       [7:0]  last accepted byte, held until the next one
//   new_code          one-cycle strobe, high when code takes a new value
//   makeBreak         1 = make byte, 0 = F0 prefix or byte following F0
//   extended          1 = E0 prefix or byte following E0
//   frame_err         one-cycle strobe on parity, stop-bit or timeout error
// ----------------------------------------------------------------------------
interface ps2_scan_rx_if;
    logic [7:0] code;
    logic       new_code;
    logic       makeBreak;
    logic       extended;
    logic       frame_err;

    modport master (
        output code,
        output new_code,
        output makeBreak,
        output extended,
        output frame_err
    );

    modport slave (
        input  code,
        input  new_code,
        input  makeBreak,
        input  extended,
        input  frame_err
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// ps2_scan_rx
// Receives device-to-host PS/2 keyboard frames from the raw ps2_clk/ps2_data
// lines and publishes one byte per valid frame on the scan-code bus, with
// F0 (break) and E0 (extended) prefix tracking and a stall watchdog.
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   ps2_clk    raw PS/2 clock line, asynchronous to clk
//   ps2_data   raw PS/2 data line, asynchronous to clk
//   kbd        scan-code bus (master): code, new_code, makeBreak,
//              extended, frame_err -- all registered
// ----------------------------------------------------------------------------
module ps2_scan_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_scan_rx_if.master      kbd
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCNT_W = 3;

    localparam logic [BYTE_W-1:0] BRK_PREFIX = 8'hF0;
    localparam logic [BYTE_W-1:0] EXT_PREFIX = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchronisers and ps2_clk glitch filter
    // ------------------------------------------------------------------------
    logic              clk_meta_q, clk_sync_q;
    logic              dat_meta_q, dat_sync_q;
    logic              filt_clk_q, filt_clk_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fall_c;

    // Lines idle high, so synchronisers reset high to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_clk_q <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
            filt_clk_q <= filt_clk_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Filtered level flips once FILTER_LEN consecutive samples disagree with it;
    // any agreeing sample restarts the run.
    always_comb begin
        filt_clk_d = filt_clk_q;
        fcnt_d     = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    // Fall is flagged in the cycle whose closing edge drops the filtered clock,
    // so data is sampled from the synchroniser in that same cycle.
    assign fall_c = filt_clk_q & ~filt_clk_d;

    // ------------------------------------------------------------------------
    // Frame FSM, watchdog and prefix tracking
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              brk_pend_q, brk_pend_d;
    logic              ext_pend_q, ext_pend_d;
    logic [BYTE_W-1:0] code_q, code_d;
    logic              new_code_q, new_code_d;
    logic              mb_q, mb_d;
    logic              ext_q, ext_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            code_q     <= '0;
            new_code_q <= 1'b0;
            mb_q       <= 1'b0;
            ext_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            code_q     <= code_d;
            new_code_q <= new_code_d;
            mb_q       <= mb_d;
            ext_q      <= ext_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        wdog_d     = wdog_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        code_d     = code_q;
        mb_d       = mb_q;
        ext_d      = ext_q;
        new_code_d = 1'b0;
        ferr_d     = 1'b0;

        // Watchdog only runs while a frame is in flight.
        if ((state_q == ST_IDLE) || fall_c) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WDOG_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                // A fall with data high is a line glitch, not a start bit.
                if (fall_c && !dat_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end

            ST_DATA: begin
                if (fall_c) begin
                    shift_d = {dat_sync_q, shift_q[BYTE_W-1:1]};
                    if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_sync_q;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    if (dat_sync_q && (^{shift_q, par_q})) begin
                        new_code_d = 1'b1;
                        code_d     = shift_q;
                        if (shift_q == BRK_PREFIX) begin
                            mb_d       = 1'b0;
                            ext_d      = ext_pend_q;
                            brk_pend_d = 1'b1;
                        end else if (shift_q == EXT_PREFIX) begin
                            mb_d       = ~brk_pend_q;
                            ext_d      = 1'b1;
                            ext_pend_d = 1'b1;
                        end else begin
                            mb_d       = ~brk_pend_q;
                            ext_d      = ext_pend_q;
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stalled frame: abandon it. A coincident fall takes priority.
        if ((state_q != ST_IDLE) && !fall_c &&
            (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1))) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            wdog_d    = '0;
            ferr_d    = 1'b1;
        end
    end

    assign kbd.code      = code_q;
    assign kbd.new_code  = new_code_q;
    assign kbd.makeBreak = mb_q;
    assign kbd.extended  = ext_q;
    assign kbd.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_rx
// Directed PS/2 frames; expected strobes are queued by the stimulus and
// popped/compared by an independent monitor on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ps2_scan_rx;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 1000;
    localparam int          HALF       = 20;   // PS/2 half-bit, in clk cycles

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       mb;
        logic       ext;
    } exp_t;

    logic clk;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_scan_rx_if kbd ();

    ps2_scan_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kbd      (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] hold_code = 8'h00;
    logic       hold_mb   = 1'b0;
    logic       hold_ext  = 1'b0;
    logic       prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_ok(input logic [7:0] c, input logic mb, input logic ext);
        exp_t e;
        e = '{err: 1'b0, code: c, mb: mb, ext: ext};
        exp_q.push_back(e);
        hold_code = c;
        hold_mb   = mb;
        hold_ext  = ext;
    endtask

    task automatic push_err();
        exp_t e;
        e = '{err: 1'b1, code: hold_code, mb: hold_mb, ext: hold_ext};
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame (11 = complete); par_flip corrupts parity.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (kbd.new_code || kbd.frame_err) begin
                chk("strobe_overlap", 32'(kbd.new_code & kbd.frame_err), 32'd0);
                chk("strobe_back_to_back", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {23'd0, kbd.frame_err, kbd.code}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_err", 32'(kbd.frame_err), 32'(e.err));
                    chk("code", 32'(kbd.code), 32'(e.code));
                    chk("makeBreak", 32'(kbd.makeBreak), 32'(e.mb));
                    chk("extended", 32'(kbd.extended), 32'(e.ext));
                end
            end
            prev_strobe <= kbd.new_code | kbd.frame_err;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_code"},      32'(kbd.code),      32'd0);
        chk({tag, "_new_code"},  32'(kbd.new_code),  32'd0);
        chk({tag, "_makeBreak"}, 32'(kbd.makeBreak), 32'd0);
        chk({tag, "_extended"},  32'(kbd.extended),  32'd0);
        chk({tag, "_frame_err"}, 32'(kbd.frame_err), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cyc(30);

        // Make code
        push_ok(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 11);
        wait_drain("drain_make");

        // Break sequence, then a plain make
        push_ok(8'hF0, 1'b0, 1'b0); send_frame(8'hF0, 1'b0, 11);
        push_ok(8'h1C, 1'b0, 1'b0); send_frame(8'h1C, 1'b0, 11);
        push_ok(8'h1C, 1'b1, 1'b0); send_frame(8'h1C, 1'b0, 11);
        wait_drain("drain_break");

        // Extended break E0 F0 75, then plain 75
        push_ok(8'hE0, 1'b1, 1'b1); send_frame(8'hE0, 1'b0, 11);
        push_ok(8'hF0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 11);
        push_ok(8'h75, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 11);
        push_ok(8'h75, 1'b1, 1'b0); send_frame(8'h75, 1'b0, 11);
        wait_drain("drain_ext_break");

        // Parity error holds previous outputs; next frame accepted
        push_err();                 send_frame(8'h1C, 1'b1, 11);
        push_ok(8'h1C, 1'b1, 1'b0); send_frame(8'h1C, 1'b0, 11);
        wait_drain("drain_parity");

        // Stalled frame after 4 data bits -> watchdog error; then 0x2A
        push_err();
        send_frame(8'h2A, 1'b0, 5);
        wait_cyc(TIMEOUT + 10);
        wait_drain("drain_timeout");
        push_ok(8'h2A, 1'b1, 1'b0); send_frame(8'h2A, 1'b0, 11);
        wait_drain("drain_after_timeout");

        // Short clock glitch with data low must not be taken as a start bit
        ps2_data = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_data = 1'b1;
        wait_cyc(30);
        // Full-length fall with data high in IDLE: no output, no error
        send_frame(8'hFF, 1'b0, 0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        push_ok(8'h1C, 1'b1, 1'b0); send_frame(8'h1C, 1'b0, 11);
        wait_drain("drain_glitch");

        // Asynchronous reset mid-frame drops it; outputs return to zero
        send_frame(8'h55, 1'b0, 5);
        #3 rst = 1'b1;
        wait_cyc(3);
        check_reset_outputs("midframe_reset");
        hold_code = 8'h00;
        hold_mb   = 1'b0;
        hold_ext  = 1'b0;
        rst = 1'b0;
        wait_cyc(30);
        check_reset_outputs("after_reset");
        push_ok(8'h1C, 1'b1, 1'b0); send_frame(8'h1C, 1'b0, 11);
        wait_drain("drain_after_reset");

        wait_cyc(50);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
